seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed scan controller for a multi-digit 7-segment
//             display sharing one BCD decoder across all digit positions.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter int SEL_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    output logic [3:0]              bcd_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int c_IDX_W = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int c_REF_W = (REFRESH_DIV > 1)  ? $clog2(REFRESH_DIV)  : 1;
    localparam int c_BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLANK_CYCLES - 1);

    localparam logic [NUM_DIGITS-1:0] c_SEL_OFF =
        (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    localparam logic [1:0] c_S_OFF   = 2'd0;
    localparam logic [1:0] c_S_BLANK = 2'd1;
    localparam logic [1:0] c_S_SHOW  = 2'd2;

    logic [1:0]              r_state;
    logic [c_IDX_W-1:0]      r_idx;
    logic [c_REF_W-1:0]      r_ref_cnt;
    logic [c_BLK_W-1:0]      r_blk_cnt;
    logic [4*NUM_DIGITS-1:0] r_active;
    logic [NUM_DIGITS-1:0]   r_active_dp;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic                    r_pending;
    logic [3:0]              r_bcd;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_sel;
    logic                    r_frame_done;

    logic [1:0]              w_state_nxt;
    logic [c_IDX_W-1:0]      w_idx_nxt;
    logic [c_REF_W-1:0]      w_ref_nxt;
    logic [c_BLK_W-1:0]      w_blk_nxt;
    logic                    w_wrap;
    logic                    w_commit;
    logic                    w_run;
    logic [NUM_DIGITS-1:0]   w_sel_hot;
    logic [3:0]              w_sel_bcd;
    logic                    w_sel_dp;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ref_nxt   = r_ref_cnt;
        w_blk_nxt   = r_blk_cnt;
        w_wrap      = 1'b0;
        case (r_state)
            c_S_OFF: begin
                w_idx_nxt = '0;
                w_ref_nxt = '0;
                w_blk_nxt = '0;
                if (enable) w_state_nxt = c_S_BLANK;
            end
            c_S_BLANK: begin
                if (r_blk_cnt == c_BLK_LAST) begin
                    w_blk_nxt   = '0;
                    w_state_nxt = c_S_SHOW;
                end else begin
                    w_blk_nxt = r_blk_cnt + 1'b1;
                end
            end
            c_S_SHOW: begin
                if (r_ref_cnt == c_REF_LAST) begin
                    w_ref_nxt   = '0;
                    w_state_nxt = c_S_BLANK;
                    if (r_idx == c_IDX_LAST) begin
                        w_idx_nxt = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_ref_nxt = r_ref_cnt + 1'b1;
                end
            end
            default: w_state_nxt = c_S_OFF;
        endcase
        // Dropping enable aborts the frame outright: no wrap, no frame_done.
        if (!enable) begin
            w_state_nxt = c_S_OFF;
            w_idx_nxt   = '0;
            w_ref_nxt   = '0;
            w_blk_nxt   = '0;
            w_wrap      = 1'b0;
        end
    end

    // Shadow reaches the display only between frames, so a frame never tears.
    assign w_commit = r_pending && ((r_state == c_S_OFF) || w_wrap);

    // Scan from the most significant digit down to track the leading-zero run.
    always_comb begin
        w_sel_bcd = 4'hF;
        w_sel_dp  = 1'b0;
        w_sel_hot = '0;
        w_run     = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_run = w_run & (r_active[4*i +: 4] == 4'd0);
            if (w_idx_nxt == c_IDX_W'(i)) begin
                w_sel_hot[i] = 1'b1;
                w_sel_dp     = r_active_dp[i];
                w_sel_bcd    = (lz_blank && (i != 0) && w_run) ? 4'hF : r_active[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_OFF;
            r_idx        <= '0;
            r_ref_cnt    <= '0;
            r_blk_cnt    <= '0;
            r_active     <= '0;
            r_active_dp  <= '0;
            r_shadow     <= '0;
            r_shadow_dp  <= '0;
            r_pending    <= 1'b0;
            r_bcd        <= 4'hF;
            r_dp         <= 1'b0;
            r_sel        <= c_SEL_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_ref_cnt    <= w_ref_nxt;
            r_blk_cnt    <= w_blk_nxt;
            r_frame_done <= w_wrap;
            if (w_commit) begin
                r_active    <= r_shadow;
                r_active_dp <= r_shadow_dp;
            end
            if (load) begin
                r_shadow    <= bcd_in;
                r_shadow_dp <= dp_in;
            end
            if (load)          r_pending <= 1'b1;
            else if (w_commit) r_pending <= 1'b0;
            if (w_state_nxt == c_S_SHOW) begin
                r_sel <= w_sel_hot ^ c_SEL_OFF;
                r_bcd <= w_sel_bcd;
                r_dp  <= w_sel_dp;
            end else begin
                r_sel <= c_SEL_OFF;
                r_bcd <= 4'hF;
                r_dp  <= 1'b0;
            end
        end
    end

    assign bcd_out    = r_bcd;
    assign dp_out     = r_dp;
    assign dig_sel    = r_sel;
    assign frame_done = r_frame_done;
    assign pending    = r_pending;

endmodule
`default_nettype wire
